// File: rtl/pcie_apb_master.sv
// APB3/APB4 initiator for single-beat PCIe endpoint requests.
// One transfer in flight, registered outputs, optional ACCESS timeout.
module pcie_apb_master #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TCNT_BITS      = 8,
  parameter logic [2:0]  PPROT          = 3'b000
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_paddr,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_pwdata,
  output logic [3:0]  o_pstrb,
  output logic [2:0]  o_pprot,
  input  logic        i_pready,
  input  logic [31:0] i_prdata,
  input  logic        i_pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TCNT_BITS-1:0] TLAST =
    TCNT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [TCNT_BITS-1:0] TMAX = '1;

  state_t               state;
  logic [TCNT_BITS-1:0] tcnt;

  assign o_pprot = PPROT;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state        <= IDLE;
      tcnt         <= '0;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= '0;
      o_resp_err   <= 1'b0;
      o_paddr      <= '0;
      o_psel       <= 1'b0;
      o_penable    <= 1'b0;
      o_pwrite     <= 1'b0;
      o_pwdata     <= '0;
      o_pstrb      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            o_req_ready <= 1'b0;
            o_paddr     <= i_req_addr;
            o_pwrite    <= i_req_write;
            o_pwdata    <= i_req_wdata;
            o_pstrb     <= i_req_write ?
                           i_req_wstrb : 4'h0;
            // misaligned requests never reach the bus
            if (i_req_addr[1:0] != 2'b00) begin
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b1;
              o_resp_rdata <= '0;
              state        <= RESP;
            end else begin
              o_psel <= 1'b1;
              state  <= SETUP;
            end
          end
        end
        SETUP: begin
          o_penable <= 1'b1;
          tcnt      <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (i_pready) begin
            o_psel       <= 1'b0;
            o_penable    <= 1'b0;
            o_resp_valid <= 1'b1;
            o_resp_rdata <= o_pwrite ? '0 : i_prdata;
            o_resp_err   <= i_pslverr;
            state        <= RESP;
          end else if (TO_EN && tcnt == TLAST) begin
            o_psel       <= 1'b0;
            o_penable    <= 1'b0;
            o_resp_valid <= 1'b1;
            o_resp_rdata <= '0;
            o_resp_err   <= 1'b1;
            state        <= RESP;
          end else if (tcnt != TMAX) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
            o_resp_rdata <= '0;
            o_resp_err   <= 1'b0;
            o_req_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_apb_master.sv
// Directed bench for pcie_apb_master: vector table plus
// reset-during-ACCESS sequence.
module tb_pcie_apb_master;

  localparam int         TO   = 4;
  localparam logic [2:0] PROT = 3'b010;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_write;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_wstrb;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic [31:0] o_paddr;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic [2:0]  o_pprot;
  logic        i_pready;
  logic [31:0] i_prdata;
  logic        i_pslverr;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  pcie_apb_master #(
    .TIMEOUT_CYCLES(TO),
    .TCNT_BITS(3),
    .PPROT(PROT)
  ) dut (
    .i_clk(i_clk),
    .i_nrst(i_nrst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr),
    .i_req_write(i_req_write),
    .i_req_wdata(i_req_wdata),
    .i_req_wstrb(i_req_wstrb),
    .o_resp_valid(o_resp_valid),
    .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata),
    .o_resp_err(o_resp_err),
    .o_paddr(o_paddr),
    .o_psel(o_psel),
    .o_penable(o_penable),
    .o_pwrite(o_pwrite),
    .o_pwdata(o_pwdata),
    .o_pstrb(o_pstrb),
    .o_pprot(o_pprot),
    .i_pready(i_pready),
    .i_prdata(i_prdata),
    .i_pslverr(i_pslverr)
  );

  // kind: 0 normal, 1 timeout, 2 misaligned
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          kind;
    int          hold;
    logic        late;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    int cyc, acc, pcnt, lat, exp_lat, exp_p;
    logic stable, held, quiet;
    logic [3:0] es;
    es      = v.wr ? v.wstrb : 4'h0;
    exp_lat = (v.kind == 0) ? 3 + v.waits :
              (v.kind == 1) ? 2 + TO : 1;
    exp_p   = (v.kind == 0) ? 2 + v.waits :
              (v.kind == 1) ? 1 + TO : 0;
    acc = 0; pcnt = 0; lat = -1; stable = 1'b1;
    i_req_valid = 1'b1;
    i_req_addr  = v.addr;
    i_req_write = v.wr;
    i_req_wdata = v.wdata;
    i_req_wstrb = v.wstrb;
    tick();
    i_req_valid = 1'b0;
    cyc = 1;
    chk("req_ready_drop", 32'(o_req_ready), 32'd0);
    while (lat < 0 && cyc < 40) begin
      if (o_resp_valid) begin
        lat = cyc;
      end else begin
        if (o_psel) begin
          pcnt++;
          if (o_paddr !== v.addr || o_pwrite !== v.wr ||
              o_pstrb !== es ||
              (v.wr && o_pwdata !== v.wdata))
            stable = 1'b0;
        end
        if (o_psel && o_penable) acc++;
        i_pready  = o_penable && (acc == v.waits + 1);
        i_prdata  = v.prdata;
        i_pslverr = v.slverr;
        tick();
        cyc++;
      end
    end
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("psel_cycles", 32'(pcnt), 32'(exp_p));
    chk("bus_stable", 32'(stable), 32'd1);
    chk("rdata", o_resp_rdata, v.exp_rdata);
    chk("err", 32'(o_resp_err), 32'(v.exp_err));
    chk("psel_in_resp", 32'(o_psel), 32'd0);
    held = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      i_pready = v.late;
      i_prdata = 32'hFFFF_FFFF;
      tick();
      i_pready = 1'b0;
      if (!o_resp_valid || o_resp_rdata !== v.exp_rdata ||
          o_resp_err !== v.exp_err || o_req_ready || o_psel)
        held = 1'b0;
    end
    if (v.hold > 0) chk("resp_held", 32'(held), 32'd1);
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;
    chk("resp_drop", 32'(o_resp_valid), 32'd0);
    chk("req_ready_back", 32'(o_req_ready), 32'd1);
    if (v.late) begin
      quiet = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (o_resp_valid || o_psel) quiet = 1'b0;
      end
      chk("no_second_resp", 32'(quiet), 32'd1);
    end
  endtask

  initial begin
    logic quiet;
    vecs[0] = '{32'h10, 1'b0, 32'h0, 4'hF, 0, 32'h1234_5678,
                1'b0, 0, 0, 1'b0, 32'h1234_5678, 1'b0};
    vecs[1] = '{32'h20, 1'b1, 32'hA5A5_0F0F, 4'b0110, 3,
                32'h7777_7777, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0};
    vecs[2] = '{32'h30, 1'b0, 32'h0, 4'hF, 1, 32'hDEAD_BEEF,
                1'b1, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{32'h34, 1'b0, 32'h0, 4'hF, 0, 32'h0BAD_F00D,
                1'b0, 0, 0, 1'b0, 32'h0BAD_F00D, 1'b0};
    vecs[4] = '{32'h50, 1'b0, 32'h0, 4'hF, 99, 32'h5555_AAAA,
                1'b0, 1, 2, 1'b1, 32'h0, 1'b1};
    vecs[5] = '{32'h3, 1'b1, 32'h1111_2222, 4'hF, 0, 32'h0,
                1'b0, 2, 5, 1'b0, 32'h0, 1'b1};
    vecs[6] = '{32'h60, 1'b0, 32'h0, 4'hF, 3, 32'hCAFE_F00D,
                1'b0, 0, 0, 1'b0, 32'hCAFE_F00D, 1'b0};
    vecs[7] = '{32'h64, 1'b1, 32'h89AB_CDEF, 4'hF, 0, 32'h4444,
                1'b1, 0, 0, 1'b0, 32'h0, 1'b1};

    i_nrst = 1'b0;
    i_req_valid = 1'b0;
    i_req_addr = '0;
    i_req_write = 1'b0;
    i_req_wdata = '0;
    i_req_wstrb = '0;
    i_resp_ready = 1'b0;
    i_pready = 1'b0;
    i_prdata = '0;
    i_pslverr = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_psel", 32'(o_psel), 32'd0);
    chk("rst_penable", 32'(o_penable), 32'd0);
    chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    chk("rst_paddr", o_paddr, 32'h0);
    chk("rst_pprot", 32'(o_pprot), 32'(PROT));
    i_nrst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run(vecs[i]);

    // reset while the slave stalls in ACCESS
    i_req_valid = 1'b1;
    i_req_addr  = 32'h70;
    i_req_write = 1'b0;
    tick();
    i_req_valid = 1'b0;
    tick();
    chk("pre_rst_access", 32'(o_psel && o_penable), 32'd1);
    i_nrst = 1'b0;
    tick();
    chk("mid_rst_psel", 32'(o_psel), 32'd0);
    chk("mid_rst_penable", 32'(o_penable), 32'd0);
    chk("mid_rst_resp_valid", 32'(o_resp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(o_req_ready), 32'd1);
    i_nrst = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_pready = (i == 1);
      tick();
      i_pready = 1'b0;
      if (o_resp_valid || o_psel) quiet = 1'b0;
    end
    chk("post_rst_quiet", 32'(quiet), 32'd1);
    run(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
